ahb_master: RTL
===============

Name: ahb_master

Overview:
- Downstream stage of the AHB2AHB bridge's ahb_slave.
- Consumes the simple request interface that ahb_slave produces (valid / rd0_wr1 / addr / wr_data) and returns ready / rd_valid / rd_data to it.
- Replays each request as a single-beat AHB transfer on the far-side AHB bus.
- Pipelines the next address phase under the current data phase, and handles the two-cycle AHB ERROR response.

Parameters:
- DATA_WIDTH, 32, width of data buses.
- ADDR_WIDTH, 32, width of address buses.
- HSIZE_VAL, 3'b010, constant value driven on o_hsize (word transfers).

Ports:
- i_clk_ahb  input  1  bus clock, single clock domain.
- i_rstn_ahb  input  1  reset, asynchronous assert, active-low.
- i_valid  input  1  request present.
- i_rd0_wr1  input  1  request direction: 0 = read, 1 = write.
- i_addr  input  ADDR_WIDTH  request address.
- i_wr_data  input  DATA_WIDTH  request write data.
- o_ready  output  1  request buffer can accept.
- o_rd_valid  output  1  one-cycle pulse: read data returned.
- o_rd_data  output  DATA_WIDTH  returned read data.
- o_err  output  1  one-cycle pulse: transfer completed with ERROR.
- o_htrans  output  1  0 = IDLE, 1 = NONSEQ (team's 1-bit HTRANS encoding).
- o_hsize  output  3  tied to HSIZE_VAL.
- o_hwrite  output  1  AHB write.
- o_haddr  output  ADDR_WIDTH  AHB address.
- o_hwdata  output  DATA_WIDTH  AHB write data.
- i_hready  input  1  AHB HREADY from bus mux.
- i_hresp  input  1  AHB HRESP: 0 = OKAY, 1 = ERROR.
- i_hrdata  input  DATA_WIDTH  AHB read data.

Behaviour:
- Reset (async, active-low): state = IDLE, request buffer empty, data-phase registers cleared.
  - All outputs 0, except o_ready = 1 and o_hsize = HSIZE_VAL.
- Request buffer (1 entry: write flag, addr, wdata):
  - o_ready = !buf_full, derived from registers only; no combinational path from i_valid or i_hready.
  - Load on i_valid && o_ready.
  - Clear when its address phase is accepted.
  - i_valid while buffer full is ignored; upstream holds it.
- Address phase (combinational from buffer and state):
  - o_htrans = buf_full && !(state==DATA && i_hresp).
  - o_haddr / o_hwrite = buffer contents while o_htrans = 1, else 0.
  - Accepted when o_htrans && i_hready. On acceptance: load dp_write and dp_wdata from the buffer, clear the buffer, state goes to DATA.
- FSM states: IDLE, DATA.
  - IDLE: no data phase outstanding. o_hwdata = 0. Transitions to DATA on address acceptance.
  - DATA: o_hwdata = dp_wdata if dp_write, else 0. Completes when i_hready = 1.
    - Completion with a new address accepted in the same cycle: stay in DATA with the new dp registers.
    - Completion with no new address: go to IDLE.
- Read completion (DATA, i_hready, !dp_write):
  - Next cycle: o_rd_valid = 1 and o_rd_data = registered i_hrdata.
  - If i_hresp = 1: o_rd_data = 0 and o_err = 1 in the same cycle.
- Write completion with i_hresp = 1: o_err pulses next cycle. A write with OKAY produces no response pulse.
- Wait states (DATA, i_hready = 0, i_hresp = 0):
  - Hold o_hwdata.
  - Hold the pipelined address/control stable.
  - o_rd_valid stays 0.
- ERROR (two cycles of i_hresp = 1: first with i_hready = 0, then i_hready = 1):
  - o_htrans forced 0 in both cycles, so the pipelined request is cancelled and stays in the buffer.
  - That request is reissued in the cycle after completion, from IDLE.
- Latency, idle bus, zero wait states:
  - Request accepted at cycle N → address phase at N+1 → data phase at N+2.
  - Read o_rd_valid at N+3.
  - Back-to-back requests sustain one transfer every 2 cycles: the 1-entry buffer refills while the previous data phase completes.
- Reset mid-transfer: state, buffer and pulses clear immediately. No completion pulse is generated for the aborted transfer.

Decomposition:
- Shared package ahb_pkg: HTRANS_IDLE / HTRANS_NONSEQ constants, HRESP_OKAY / HRESP_ERROR, HSIZE encodings, master state enum.
- ahb_pkg is used by both ahb_slave and ahb_master.
- One sub-module: ahb_req_buf, the 1-entry request register with full flag, load and clear.

Test Plan:
- Single read: i_valid, addr = 0x0000_0010, hready = 1, hrdata = 0xDEAD_BEEF → htrans = 1 with haddr = 0x10 one cycle later; o_rd_valid = 1 with o_rd_data = 0xDEADBEEF 2 cycles after that; o_err = 0.
- Single write: addr = 0x20, wdata = 0x1234_5678 → o_hwrite = 1 during the address phase; o_hwdata = 0x12345678 in the following cycle; no o_rd_valid.
- Wait states: read with hready held low for 3 data-phase cycles → o_hwdata / o_haddr stable throughout; o_rd_valid exactly once, 1 cycle after hready rises.
- Pipelining: write 0x30 then read 0x34 queued → address 0x34 driven during the data phase of 0x30; both complete in order; one o_rd_valid.
- Error: read 0x40 with queued write 0x44; slave gives hresp = 1 / hready = 0, then hresp = 1 / hready = 1 → htrans = 0 in both cycles; o_err and o_rd_valid pulse with o_rd_data = 0; 0x44 reissued the next cycle.
- Reset mid data phase: deassert i_rstn_ahb while in DATA → all outputs 0 (o_ready = 1) immediately; no pulses after reset release.

Source files
------------

// File: rtl/ahb_pkg.sv
// ============================================================================
// Module      : ahb_pkg
// Description : AHB encodings and master state codes shared by the bridge.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

    localparam logic       HTRANS_IDLE   = 1'b0;
    localparam logic       HTRANS_NONSEQ = 1'b1;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam int unsigned MST_STATE_W  = 1;
    localparam logic [MST_STATE_W-1:0] MST_IDLE = 1'b0;
    localparam logic [MST_STATE_W-1:0] MST_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ahb_req_buf.sv
// ============================================================================
// Module      : ahb_req_buf
// Description : Single-entry request register (direction, address, data).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ahb_req_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rstn_ahb,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_full,
    output logic                  o_write,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata
);

    logic                  r_full;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    // Load only happens while empty and clear only while full, so they never collide.
    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            r_full  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_clear) begin
            r_full  <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_write <= i_write;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    assign o_full  = r_full;
    assign o_write = r_write;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;

endmodule

`default_nettype wire

// File: rtl/ahb_master.sv
// ============================================================================
// Module      : ahb_master
// Description : Replays bridge requests as single-beat pipelined AHB transfers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ahb_master
    import ahb_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ADDR_WIDTH = 32,
    parameter logic [2:0] HSIZE_VAL  = HSIZE_WORD
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rstn_ahb,
    input  logic                  i_valid,
    input  logic                  i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_err,
    output logic                  o_htrans,
    output logic [2:0]            o_hsize,
    output logic                  o_hwrite,
    output logic [ADDR_WIDTH-1:0] o_haddr,
    output logic [DATA_WIDTH-1:0] o_hwdata,
    input  logic                  i_hready,
    input  logic                  i_hresp,
    input  logic [DATA_WIDTH-1:0] i_hrdata
);

    logic [MST_STATE_W-1:0] r_state;
    logic [MST_STATE_W-1:0] w_state_nxt;

    logic                  w_buf_full;
    logic                  w_buf_write;
    logic [ADDR_WIDTH-1:0] w_buf_addr;
    logic [DATA_WIDTH-1:0] w_buf_wdata;

    logic                  w_load;
    logic                  w_accept;
    logic                  w_in_data;
    logic                  w_complete;
    logic                  w_htrans;

    logic                  r_dp_write;
    logic [DATA_WIDTH-1:0] r_dp_wdata;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_err;

    assign w_load     = i_valid && !w_buf_full;
    assign w_in_data  = (r_state == MST_DATA);
    assign w_complete = w_in_data && i_hready;
    assign w_accept   = w_htrans && i_hready;

    ahb_req_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_req_buf (
        .i_clk_ahb  (i_clk_ahb),
        .i_rstn_ahb (i_rstn_ahb),
        .i_load     (w_load),
        .i_clear    (w_accept),
        .i_write    (i_rd0_wr1),
        .i_addr     (i_addr),
        .i_wdata    (i_wr_data),
        .o_full     (w_buf_full),
        .o_write    (w_buf_write),
        .o_addr     (w_buf_addr),
        .o_wdata    (w_buf_wdata)
    );

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            r_state <= MST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MST_IDLE: if (w_accept) w_state_nxt = MST_DATA;
            MST_DATA: if (i_hready && !w_accept) w_state_nxt = MST_IDLE;
            default:  w_state_nxt = MST_IDLE;
        endcase
    end

    // The pipelined request is withheld during both ERROR cycles so it stays buffered.
    always_comb begin
        w_htrans = HTRANS_IDLE;
        o_haddr  = '0;
        o_hwrite = 1'b0;
        o_hwdata = '0;
        if (w_buf_full && !(w_in_data && i_hresp == HRESP_ERROR)) begin
            w_htrans = HTRANS_NONSEQ;
            o_haddr  = w_buf_addr;
            o_hwrite = w_buf_write;
        end
        if (w_in_data && r_dp_write) begin
            o_hwdata = r_dp_wdata;
        end
    end

    always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
        if (!i_rstn_ahb) begin
            r_dp_write <= 1'b0;
            r_dp_wdata <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_complete && !r_dp_write;
            r_err      <= w_complete && (i_hresp == HRESP_ERROR);
            if (w_complete && !r_dp_write) begin
                r_rd_data <= (i_hresp == HRESP_ERROR) ? '0 : i_hrdata;
            end
            if (w_accept) begin
                r_dp_write <= w_buf_write;
                r_dp_wdata <= w_buf_wdata;
            end
        end
    end

    assign o_ready    = !w_buf_full;
    assign o_htrans   = w_htrans;
    assign o_hsize    = HSIZE_VAL;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_err      = r_err;

endmodule

`default_nettype wire
